wb_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone arbiter in the clk_sys domain.
- Shares the SDRAM Wishbone slave between the APF bridge Wishbone master (m0) and the SoC CPU/DMA master (m1).
- Round-robin grant. A grant is held for the whole cyc assertion, so bursts and read-modify-write sequences are never split.
- Wishbone signals are routed combinationally once the registered grant is set.

---
 rtl/wb_arbiter_2m.sv | 143 ++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master round-robin Wishbone arbiter, grant held per cyc; stall timeout via WB_ARB_TIMEOUT_EN
module wb_arbiter_2m #(
    parameter int ADDR_WIDTH     = 30,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_data_write,
    input  logic [DATA_WIDTH/8-1:0] m0_sel,
    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [2:0]              m0_cti,
    input  logic [1:0]              m0_bte,
    output logic                    m0_ack,
    output logic                    m0_err,
    output logic [DATA_WIDTH-1:0]   m0_data_read,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_data_write,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [2:0]              m1_cti,
    input  logic [1:0]              m1_bte,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic [DATA_WIDTH-1:0]   m1_data_read,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_data_write,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [2:0]              s_cti,
    output logic [1:0]              s_bte,
    input  logic                    s_ack,
    input  logic                    s_err,
    input  logic [DATA_WIDTH-1:0]   s_data_read,
    output logic [1:0]              grant,
    output logic                    timeout_flag
);
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
`ifdef WB_ARB_TIMEOUT_EN
        GNT1  = 2'd2,
        ABORT = 2'd3
`else
        GNT1  = 2'd2
`endif
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   g0, g1, to_hit;

    assign g0           = (state_q == GNT0);
    assign g1           = (state_q == GNT1);
    assign grant        = {g1, g0};
    assign m0_data_read = s_data_read;
    assign m1_data_read = s_data_read;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        flag_q, flag_d, stalled;

    // count consecutive stalled strobe cycles of the granted master; restart on any exit
    always_comb begin
        stalled = (g0 | g1) & s_cyc & s_stb & ~s_ack & ~s_err;
        to_hit  = stalled && (stall_q == 16'(TIMEOUT_CYCLES - 1));
        stall_d = (stalled && state_d == state_q) ? stall_q + 16'd1 : '0;
        flag_d  = flag_q | to_hit;
    end

    // stall counter and sticky abort flag
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            flag_q  <= flag_d;
        end
    end

    assign timeout_flag = flag_q;
`else
    assign to_hit       = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // arbitration: ties go opposite last_q; a grant lasts until its cyc drops
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (m0_cyc && (!m1_cyc || last_q)) ? GNT0 : m1_cyc ? GNT1 : IDLE;
`ifdef WB_ARB_TIMEOUT_EN
            GNT0:    state_d = !m0_cyc ? IDLE : to_hit ? ABORT : GNT0;
            GNT1:    state_d = !m1_cyc ? IDLE : to_hit ? ABORT : GNT1;
            ABORT:   state_d = (last_q ? m1_cyc : m0_cyc) ? ABORT : IDLE;
`else
            GNT0:    state_d = m0_cyc ? GNT0 : IDLE;
            GNT1:    state_d = m1_cyc ? GNT1 : IDLE;
`endif
            default: state_d = IDLE;
        endcase
        last_d = (state_d == GNT0) ? 1'b0 : (state_d == GNT1) ? 1'b1 : last_q;
    end

    // state register; last_q starts at m1 so m0 wins the first tie
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // route the granted master to the slave; everything quiet when no grant
    always_comb begin
        s_addr       = g0 ? m0_addr       : g1 ? m1_addr       : '0;
        s_data_write = g0 ? m0_data_write : g1 ? m1_data_write : '0;
        s_sel        = g0 ? m0_sel        : g1 ? m1_sel        : '0;
        s_cyc        = g0 ? m0_cyc        : g1 ? m1_cyc        : 1'b0;
        s_stb        = g0 ? m0_stb        : g1 ? m1_stb        : 1'b0;
        s_we         = g0 ? m0_we         : g1 ? m1_we         : 1'b0;
        s_cti        = g0 ? m0_cti        : g1 ? m1_cti        : '0;
        s_bte        = g0 ? m0_bte        : g1 ? m1_bte        : '0;
        m0_ack       = g0 & s_ack;
        m1_ack       = g1 & s_ack;
        m0_err       = g0 & (s_err | to_hit);
        m1_err       = g1 & (s_err | to_hit);
    end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed and random checks of wb_arbiter_2m against a cycle-level arbitration model
module tb_wb_arbiter_2m;
    localparam int AW = 30, DW = 32, SW = 4, TO = 8;

    logic          clk_sys = 1'b0, reset_n = 1'b0;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd   [2];
    logic [SW-1:0] sel  [2];
    logic          cyc  [2], stb [2], we [2];
    logic [2:0]    cti  [2];
    logic [1:0]    bte  [2];
    logic          ack  [2], err [2];
    logic [DW-1:0] rd   [2];
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data_write, s_rd;
    logic [SW-1:0] s_sel;
    logic          s_cyc, s_stb, s_we, s_ack, s_err;
    logic [2:0]    s_cti;
    logic [1:0]    s_bte;
    logic [1:0]    grant;
    logic          timeout_flag;

    int n_chk = 0, n_bad = 0;
    int own = -1, last = 1, stall = 0;
    bit flag = 0;
    int acks [2], errs [2];

    wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .m0_addr(addr[0]), .m0_data_write(wd[0]), .m0_sel(sel[0]), .m0_cyc(cyc[0]), .m0_stb(stb[0]),
        .m0_we(we[0]), .m0_cti(cti[0]), .m0_bte(bte[0]), .m0_ack(ack[0]), .m0_err(err[0]), .m0_data_read(rd[0]),
        .m1_addr(addr[1]), .m1_data_write(wd[1]), .m1_sel(sel[1]), .m1_cyc(cyc[1]), .m1_stb(stb[1]),
        .m1_we(we[1]), .m1_cti(cti[1]), .m1_bte(bte[1]), .m1_ack(ack[1]), .m1_err(err[1]), .m1_data_read(rd[1]),
        .s_addr(s_addr), .s_data_write(s_data_write), .s_sel(s_sel), .s_cyc(s_cyc), .s_stb(s_stb),
        .s_we(s_we), .s_cti(s_cti), .s_bte(s_bte), .s_ack(s_ack), .s_err(s_err), .s_data_read(s_rd),
        .grant(grant), .timeout_flag(timeout_flag)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit tohit();
`ifdef WB_ARB_TIMEOUT_EN
        return (own == 0 || own == 1) && cyc[own] && stb[own] && !s_ack && !s_err && stall == TO - 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        own = -1; last = 1; stall = 0; flag = 0;
    endtask

    task automatic model_edge();
        bit th;
        th = tohit();
        if (!reset_n) model_reset();
        else if (own == -1) begin
            if (cyc[0] && cyc[1]) own = (last == 1) ? 0 : 1;
            else if (cyc[0]) own = 0;
            else if (cyc[1]) own = 1;
            if (own >= 0) last = own;
            stall = 0;
        end else if (own == 2) begin
            if (!cyc[last]) own = -1;
        end else if (!cyc[own]) begin
            own = -1; stall = 0;
        end else if (th) begin
            own = 2; flag = 1; stall = 0;
        end else stall = (stb[own] && !s_ack && !s_err) ? stall + 1 : 0;
    endtask

    task automatic check_all();
        bit on;
        int k;
        on = (own == 0 || own == 1);
        k  = on ? own : 0;
        check("s_cyc",  64'(s_cyc),        on ? 64'(cyc[k])  : 64'd0);
        check("s_stb",  64'(s_stb),        on ? 64'(stb[k])  : 64'd0);
        check("s_we",   64'(s_we),         on ? 64'(we[k])   : 64'd0);
        check("s_addr", 64'(s_addr),       on ? 64'(addr[k]) : 64'd0);
        check("s_wd",   64'(s_data_write), on ? 64'(wd[k])   : 64'd0);
        check("s_sel",  64'(s_sel),        on ? 64'(sel[k])  : 64'd0);
        check("s_cti",  64'(s_cti),        on ? 64'(cti[k])  : 64'd0);
        check("s_bte",  64'(s_bte),        on ? 64'(bte[k])  : 64'd0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("m%0d_ack", i), 64'(ack[i]), 64'(on && own == i && s_ack));
            check($sformatf("m%0d_err", i), 64'(err[i]), 64'(on && own == i && (s_err || tohit())));
            check($sformatf("m%0d_rd", i),  64'(rd[i]),  64'(s_rd));
            acks[i] += int'(ack[i]);
            errs[i] += int'(err[i]);
        end
        check("grant", 64'(grant), own == 0 ? 64'd1 : own == 1 ? 64'd2 : 64'd0);
        check("tflag", 64'(timeout_flag), 64'(flag));
    endtask

    task automatic tick();
        @(negedge clk_sys);
        check_all();
        @(posedge clk_sys);
        model_edge();
        #1;
    endtask

    task automatic set_m(input int i, input logic c, input logic s, input logic w);
        cyc[i] = c; stb[i] = s; we[i] = w;
    endtask

    task automatic clear_counts();
        acks[0] = 0; acks[1] = 0; errs[0] = 0; errs[1] = 0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wd[i] = '0; sel[i] = '0; cti[i] = '0; bte[i] = '0;
            set_m(i, 0, 0, 0);
        end
        s_ack = 0; s_err = 0; s_rd = 32'h1234_5678;
        clear_counts();
        repeat (3) tick();
        reset_n = 1;
        tick();

        // tie from reset: m0, one idle cycle, m1, then m0 again
        set_m(0, 1, 1, 0); set_m(1, 1, 1, 0);
        tick();
        check("tie_first", 64'(grant), 64'd1);
        tick();
        set_m(0, 0, 0, 0);
        tick();
        check("tie_gap", 64'(grant), 64'd0);
        tick();
        check("tie_second", 64'(grant), 64'd2);
        set_m(1, 0, 0, 0);
        tick();
        set_m(0, 1, 1, 0); set_m(1, 1, 1, 0);
        tick();
        check("tie_third", 64'(grant), 64'd1);
        set_m(0, 0, 0, 0); set_m(1, 0, 0, 0);
        tick(); tick();

        // single m0 write, slave acks two cycles after s_stb
        clear_counts();
        addr[0] = 30'h100; wd[0] = 32'hDEAD_BEEF; sel[0] = 4'hF;
        set_m(0, 1, 1, 1);
        tick();
        check("wr_grant", 64'(grant), 64'd1);
        check("wr_addr", 64'(s_addr), 64'h100);
        check("wr_data", 64'(s_data_write), 64'hDEAD_BEEF);
        tick(); tick();
        s_ack = 1;
        tick();
        s_ack = 0; set_m(0, 0, 0, 0);
        tick();
        check("wr_release", 64'(grant), 64'd0);
        check("wr_acks", 64'(acks[0]), 64'd1);

        // m1 4-beat burst, m0 requests mid-burst, last ack coincides with cyc drop
        clear_counts();
        cti[1] = 3'b010; bte[1] = 2'b00;
        set_m(1, 1, 1, 0);
        tick();
        check("burst_grant", 64'(grant), 64'd2);
        for (int b = 0; b < 4; b++) begin
            s_ack = 1; s_rd = $urandom;
            if (b == 1) set_m(0, 1, 1, 0);
            if (b == 3) begin cti[1] = 3'b111; set_m(1, 0, 0, 0); end
            tick();
        end
        s_ack = 0;
        check("burst_rel", 64'(grant), 64'd0);
        tick();
        check("burst_m0", 64'(grant), 64'd1);
        check("burst_m1_acks", 64'(acks[1]), 64'd4);
        check("burst_m0_acks", 64'(acks[0]), 64'd0);
        set_m(0, 0, 0, 0);
        tick(); tick();

        // stray slave responses while idle
        clear_counts();
        s_ack = 1; s_err = 1;
        tick(); tick();
        check("stray_grant", 64'(grant), 64'd0);
        check("stray_acks", 64'(acks[0] + acks[1] + errs[0] + errs[1]), 64'd0);
        s_ack = 0; s_err = 0;
        tick();

        // stalled slave: abort with timeout, otherwise held forever
        clear_counts();
        set_m(0, 1, 1, 0);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        begin
            int n = 0;
            while (errs[0] == 0 && n < 40) begin tick(); n++; end
            check("to_latency", 64'(n), 64'(TO));
            check("to_scyc", 64'(s_cyc), 64'd0);
            check("to_flag", 64'(timeout_flag), 64'd1);
        end
        tick();
        set_m(0, 0, 0, 0);
        tick();
        check("to_idle", 64'(grant), 64'd0);
        set_m(1, 1, 1, 1);
        tick();
        check("to_m1_grant", 64'(grant), 64'd2);
        s_ack = 1;
        tick();
        s_ack = 0; set_m(1, 0, 0, 0);
        tick();
        check("to_m1_ack", 64'(acks[1]), 64'd1);
`else
        repeat (40) tick();
        check("stall_hold", 64'(grant), 64'd1);
        check("stall_flag", 64'(timeout_flag), 64'd0);
        set_m(0, 0, 0, 0);
        tick();
`endif

        // random traffic against the model
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 2; i++) begin
                cyc[i]  = cyc[i] ? ($urandom % 6 != 0) : ($urandom % 4 == 0);
                stb[i]  = cyc[i] && ($urandom % 4 != 0);
                we[i]   = $urandom % 2 == 0;
                addr[i] = AW'($urandom);
                wd[i]   = $urandom;
                sel[i]  = SW'($urandom);
                cti[i]  = 3'($urandom);
                bte[i]  = 2'($urandom);
            end
            s_ack = ($urandom % 3 == 0);
            s_err = ($urandom % 16 == 0);
            s_rd  = $urandom;
            tick();
        end
        set_m(0, 0, 0, 0); set_m(1, 0, 0, 0); s_ack = 0; s_err = 0;
        tick(); tick();

        // asynchronous reset during m1's strobe
        set_m(1, 1, 1, 1);
        tick(); tick();
        check("rst_pre_grant", 64'(grant), 64'd2);
        reset_n = 0;
        model_reset();
        #1;
        check("rst_scyc", 64'(s_cyc), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        tick(); tick();
        reset_n = 1;
        set_m(0, 1, 1, 0);
        tick();
        check("rst_tie", 64'(grant), 64'd1);
        set_m(0, 0, 0, 0); set_m(1, 0, 0, 0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
